// File: rtl/lsu_mw.sv
// Multi-cycle load/store unit: checks alignment and funct3, runs one bus transaction
// with an ack timeout, then aligns and extends the load result.
module lsu_mw #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       off_q, off_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [29:0]      mem_addr_q, mem_addr_d;
  logic [3:0]       mem_be_q, mem_be_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [31:0]      load_data_q, load_data_d;

  logic             legal, misal;
  logic [3:0]       be_new;
  logic [31:0]      wd_new;
  logic [31:0]      rsh;
  logic [31:0]      ld_ext;

  assign stall = (state_q == S_BUS) || ((state_q == S_IDLE) && req_valid);

  // Request decode: legality, alignment, byte enables and lane replication
  always_comb begin
    legal  = req_we ? (funct3 inside {3'b000, 3'b001, 3'b010})
                    : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misal  = ((funct3[1:0] == 2'b01) && addr[0]) ||
             ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    be_new = 4'b1111;
    wd_new = wdata;
    if (req_we) begin
      case (funct3[1:0])
        2'b00:   begin be_new = 4'b0001 << addr[1:0]; wd_new = {4{wdata[7:0]}}; end
        2'b01:   begin be_new = addr[1] ? 4'b1100 : 4'b0011; wd_new = {2{wdata[15:0]}}; end
        default: begin be_new = 4'b1111; wd_new = wdata; end
      endcase
    end
  end

  // Load alignment: halves are aligned, so one byte-granular shift serves both widths
  always_comb begin
    rsh = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_ext = {{24{rsh[7]}}, rsh[7:0]};
      3'b001:  ld_ext = {{16{rsh[15]}}, rsh[15:0]};
      3'b100:  ld_ext = {24'b0, rsh[7:0]};
      3'b101:  ld_ext = {16'b0, rsh[15:0]};
      default: ld_ext = rsh;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    f3_d        = f3_q;
    off_d       = off_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    err_d       = err_q;
    load_data_d = load_data_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (legal && !misal) begin
            state_d     = S_BUS;
            cnt_d       = '0;
            f3_d        = funct3;
            off_d       = addr[1:0];
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = addr[31:2];
            mem_be_d    = be_new;
            mem_wdata_d = wd_new;
          end else begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            err_d       = 1'b1;
            load_data_d = '0;
          end
        end
      end
      S_BUS: begin
        if (mem_ack) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          err_d       = 1'b0;
          load_data_d = mem_we_q ? 32'd0 : ld_ext;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          err_d       = 1'b1;
          load_data_d = '0;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      load_data_q <= load_data_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign load_data = load_data_q;

endmodule

// File: tb/tb_lsu_mw.sv
// Bench for lsu_mw (TIMEOUT=4): a driver models the pipeline and bus, a monitor
// pops expected {err, load_data} entries from a scoreboard queue on every done.
module tb_lsu_mw;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, done, err;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  // entry: {check_load_data, err, load_data}
  logic [33:0] exp_q[$];

  lsu_mw #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
    .load_data(load_data), .err(err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        chk("err", 32'(err), 32'(e[32]));
        if (e[33]) chk("load_data", load_data, e[31:0]);
      end
    end
  end

  // One request; ack_at is the 1-based BUS cycle carrying mem_ack (0 = never)
  task automatic run_req(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int ack_at,
                         input logic exp_err, input logic chk_ld, input logic [31:0] exp_ld,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd,
                         input int exp_stalls, input int exp_bus);
    int stalls = 0;
    int bus    = 0;
    int cyc    = 0;
    exp_q.push_back({chk_ld, exp_err, exp_ld});
    req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
    mem_rdata = rd;
    while (!done && cyc < 40) begin
      #1;
      if (stall) stalls++;
      if (mem_req) begin
        bus++;
        if (bus == 1) begin
          chk({name, "_mem_addr"}, 32'(mem_addr), 32'(a[31:2]));
          chk({name, "_mem_be"},   32'(mem_be), 32'(exp_be));
          chk({name, "_mem_we"},   32'(mem_we), 32'(we));
          if (we) chk({name, "_mem_wdata"}, mem_wdata, exp_wd);
        end
        mem_ack = (bus == ack_at);
      end
      @(negedge clk);
      mem_ack = 1'b0;
      cyc++;
    end
    chk({name, "_done_seen"}, 32'(done), 32'd1);
    chk({name, "_stalls"}, 32'(stalls), 32'(exp_stalls));
    chk({name, "_bus_cycles"}, 32'(bus), 32'(exp_bus));
    chk({name, "_stall_in_done"}, 32'(stall), 32'd0);
    chk({name, "_req_low_at_done"}, 32'(mem_req), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; funct3 = '0;
    addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_done_err", 32'({done, err, mem_we}), 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_stall", 32'(stall), 32'd0);

    //       name    we    f3      addr        wdata         rdata     ack er cl  exp_ld        be       wd        st bus
    run_req("lw",    1'b0, 3'b010, 32'h104, 32'h0,        32'hDEADBEEF, 1, 0, 1, 32'hDEADBEEF, 4'hF, 32'h0,        2, 1);
    run_req("tmo",   1'b0, 3'b010, 32'h200, 32'h0,        32'h12345678, 0, 1, 1, 32'h0,        4'hF, 32'h0,        5, 4);
    run_req("lb",    1'b0, 3'b000, 32'h103, 32'h0,        32'h80112233, 4, 0, 1, 32'hFFFFFF80, 4'hF, 32'h0,        5, 4);
    run_req("lbu",   1'b0, 3'b100, 32'h103, 32'h0,        32'h80112233, 2, 0, 1, 32'h00000080, 4'hF, 32'h0,        3, 2);
    run_req("sh",    1'b1, 3'b001, 32'h006, 32'h1234ABCD, 32'hFFFFFFFF, 1, 0, 1, 32'h0,        4'hC, 32'hABCDABCD, 2, 1);
    run_req("lh",    1'b0, 3'b001, 32'h102, 32'h0,        32'h80112233, 3, 0, 1, 32'hFFFF8011, 4'hF, 32'h0,        4, 3);
    run_req("lhu",   1'b0, 3'b101, 32'h100, 32'h0,        32'h80119233, 1, 0, 1, 32'h00009233, 4'hF, 32'h0,        2, 1);
    run_req("lb0",   1'b0, 3'b000, 32'h100, 32'h0,        32'h8011227F, 1, 0, 1, 32'h0000007F, 4'hF, 32'h0,        2, 1);
    run_req("sb",    1'b1, 3'b000, 32'h005, 32'h000000EF, 32'h0,        2, 0, 1, 32'h0,        4'h2, 32'hEFEFEFEF, 3, 2);
    run_req("sw",    1'b1, 3'b010, 32'h3FC, 32'hCAFEF00D, 32'h0,        1, 0, 1, 32'h0,        4'hF, 32'hCAFEF00D, 2, 1);
    run_req("lw_mis",1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        1, 1, 0, 32'h0,        4'hF, 32'h0,        1, 0);
    run_req("f3_011",1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        1, 1, 0, 32'h0,        4'hF, 32'h0,        1, 0);
    run_req("lh_mis",1'b0, 3'b001, 32'h101, 32'h0,        32'h0,        1, 1, 0, 32'h0,        4'hF, 32'h0,        1, 0);
    run_req("st_100",1'b1, 3'b100, 32'h100, 32'h0,        32'h0,        1, 1, 0, 32'h0,        4'hF, 32'h0,        1, 0);

    // Reset in the 2nd BUS cycle; the late ack lands in IDLE and must be ignored
    req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h40; mem_rdata = 32'h55AA55AA;
    @(negedge clk);
    chk("rst_bus_req_c1", 32'(mem_req), 32'd1);
    @(negedge clk);
    chk("rst_bus_req_c2", 32'(mem_req), 32'd1);
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_bus_req_after", 32'(mem_req), 32'd0);
    chk("rst_bus_done_after", 32'(done), 32'd0);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("rst_bus_idle_stall", 32'(stall), 32'd0);
    chk("rst_bus_no_done", 32'(done), 32'd0);
    chk("rst_bus_no_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    chk("rst_bus_no_done2", 32'(done), 32'd0);

    run_req("lw_after_rst", 1'b0, 3'b010, 32'h108, 32'h0, 32'h0BADF00D, 1, 0, 1, 32'h0BADF00D, 4'hF, 32'h0, 2, 1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_mw.md
LSU_MW -- requirements
Module: lsu_mw

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles waited for mem_ack before a bus error is declared.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  memory-stage instruction is a load/store; held stable by the pipeline while stall=1.
REQ-005 req_we  input  1  1=store, 0=load.
REQ-006 funct3  input  3  RV32I width/sign code (inst[14:12]).
REQ-007 addr  input  32  byte address (ALU result).
REQ-008 wdata  input  32  store data (rs2).
REQ-009 stall  output  1  freeze all upstream pipeline registers and PC.
REQ-010 done  output  1  one-cycle completion pulse; load_data/err valid in the same cycle.
REQ-011 load_data  output  32  aligned, extended load result for the writeback mux.
REQ-012 err  output  1  access fault (misaligned, illegal funct3 or timeout), qualified by done.
REQ-013 mem_req  output  1  bus request, held until mem_ack or timeout.
REQ-014 mem_we  output  1  bus write strobe, valid while mem_req=1.
REQ-015 mem_addr  output  30  word address (addr[31:2]).
REQ-016 mem_be  output  4  byte enables.
REQ-017 mem_wdata  output  32  lane-replicated store data.
REQ-018 mem_ack  input  1  bus completion, single-cycle pulse; mem_rdata valid with it.
REQ-019 mem_rdata  input  32  read word.

Function
REQ-020 FSM states SHALL be IDLE, BUS and DONE.
REQ-021 IDLE: req_valid=1 with a legal, aligned request latches we/funct3/addr/wdata and moves to BUS; an illegal or misaligned request moves to DONE with err set and no bus activity.
REQ-022 Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000, 001, 010; all other codes are illegal.
REQ-023 Misaligned: halfword with addr[0]=1; word with addr[1:0]!=00.
REQ-024 stall SHALL be combinational: 1 in IDLE whenever req_valid=1, and 1 in BUS; 0 in DONE.
REQ-025 BUS: mem_req=1, driven from registers only; mem_ack=1 moves to DONE; the wait counter increments each BUS cycle.
REQ-026 When the counter reaches TIMEOUT without an ack, the FSM SHALL drop mem_req, enter DONE with err=1 and set load_data=0.
REQ-027 DONE lasts exactly one cycle with done=1, then returns to IDLE; req_valid is not sampled in DONE.
REQ-028 mem_be: SB = 0001<<addr[1:0]; SH = 0011<<(2*addr[1]); SW = 1111; loads = 1111.
REQ-029 mem_wdata: SB = {4{wdata[7:0]}}; SH = {2{wdata[15:0]}}; SW = wdata.
REQ-030 Load data is captured on mem_ack: the selected byte/half is shifted to bit 0, sign-extended for LB/LH and zero-extended for LBU/LHU; it is held until the next done.
REQ-031 For stores, load_data SHALL be 0 at done.
REQ-032 Minimum latency is ack-in-first-BUS-cycle: accept (cycle 0), BUS (cycle 1), DONE (cycle 2); 2 stall cycles.
REQ-033 A mem_ack arriving in IDLE or DONE SHALL be ignored.
REQ-034 If ack and timeout occur in the same cycle, the ack wins and err=0.

Reset
REQ-035 During reset: state=IDLE, counter=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, done=0, err=0, load_data=0; stall=0 on the cycle after reset is released unless req_valid=1.
REQ-036 Reset asserted in BUS SHALL deassert mem_req at that edge and abandon the access with no done pulse.

Verification
REQ-037 LW at addr 0x104, mem_rdata 0xDEADBEEF, ack in first BUS cycle -> mem_addr=0x41, mem_be=1111, stall for 2 cycles, done with load_data=0xDEADBEEF, err=0.
REQ-038 LB at addr 0x103, rdata 0x80112233, ack after 3 BUS cycles -> load_data=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-039 SH at addr 0x06, wdata 0x1234ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD; done with load_data=0.
REQ-040 LW at addr 0x102 -> mem_req never asserts, 1 stall cycle, then done=1 with err=1; funct3=011 gives the same response.
REQ-041 TIMEOUT=4 with no ack -> mem_req high for 4 cycles then low, done=1, err=1, load_data=0.
REQ-042 Reset pulsed in the 2nd BUS cycle, with an ack arriving 1 cycle later -> mem_req low after the reset edge, no done pulse, FSM in IDLE.
